// File: rtl/lcd_hd44780_responder.sv
// Responder-side model of an HD44780 8-bit write bus: decodes strobed writes into a
// 16x2 display RAM mirror, address counter, entry mode and busy flag. Never drives the bus.
module lcd_hd44780_responder #(
  parameter int CMD_CYCLES  = 2000,
  parameter int LONG_CYCLES = 76500
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST_N,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] DATA_BUS,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       busy,
  output logic       display_on,
  output logic [6:0] ac,
  output logic       wr_pulse,
  output logic       overrun
);

  localparam int MAXC = (LONG_CYCLES > CMD_CYCLES) ? LONG_CYCLES : CMD_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state_q, state_d;
  logic [4:0]      fill_idx;
  logic [7:0]      mem [32];
  logic            inc;
  logic [CW-1:0]   cnt;

  logic            e_s1, e_s2, e_d;
  logic            rs_s1, rs_s2, rw_s1, rw_s2;
  logic [7:0]      d_s1, d_s2;
  logic            hold_rs, hold_rw;
  logic [7:0]      hold_d;
  logic            txn_v, txn_rs, txn_rw;
  logic [7:0]      txn_d;

  logic            fall, accept, is_instr, is_data, wr_en;
  logic            op_setac, op_disp, op_entry, op_home, op_clear;
  logic [4:0]      wr_idx;

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) ac_step = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else    ac_step = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
  endfunction

  // hold_* tracks the bus while synchronized E is high, so at the falling edge it
  // holds the sample aligned with the last E-high cycle.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      e_s1 <= 1'b0; e_s2 <= 1'b0; e_d <= 1'b0;
      rs_s1 <= 1'b0; rs_s2 <= 1'b0; rw_s1 <= 1'b0; rw_s2 <= 1'b0;
      d_s1 <= 8'h00; d_s2 <= 8'h00;
      hold_rs <= 1'b0; hold_rw <= 1'b0; hold_d <= 8'h00;
      txn_v <= 1'b0; txn_rs <= 1'b0; txn_rw <= 1'b0; txn_d <= 8'h00;
    end else begin
      e_s1 <= LCD_E;   e_s2 <= e_s1;   e_d <= e_s2;
      rs_s1 <= LCD_RS; rs_s2 <= rs_s1;
      rw_s1 <= LCD_RW; rw_s2 <= rw_s1;
      d_s1 <= DATA_BUS; d_s2 <= d_s1;
      if (e_s2) begin
        hold_rs <= rs_s2; hold_rw <= rw_s2; hold_d <= d_s2;
      end
      txn_v <= fall;
      if (fall) begin
        txn_rs <= hold_rs; txn_rw <= hold_rw; txn_d <= hold_d;
      end
    end
  end

  assign fall     = e_d & ~e_s2;
  assign accept   = txn_v & ~txn_rw & ~busy;
  assign is_instr = accept & ~txn_rs;
  assign is_data  = accept & txn_rs;
  assign wr_en    = is_data & ((ac[6:4] == 3'b000) | (ac[6:4] == 3'b100));
  assign wr_idx   = {ac[6], ac[3:0]};

  // Highest set bit selects the instruction; CGRAM, Function Set and shift fall to default.
  always_comb begin
    op_setac = 1'b0; op_disp = 1'b0; op_entry = 1'b0; op_home = 1'b0; op_clear = 1'b0;
    casez (txn_d)
      8'b1???????: op_setac = 1'b1;
      8'b00001???: op_disp  = 1'b1;
      8'b000001??: op_entry = 1'b1;
      8'b0000001?: op_home  = 1'b1;
      8'b00000001: op_clear = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (is_instr && op_clear) state_d = FILL;
      FILL: if (fill_idx == 5'd31)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
      ac         <= 7'h00;
      inc        <= 1'b1;
      display_on <= 1'b0;
      wr_pulse   <= 1'b0;
      overrun    <= 1'b0;
      rd_char    <= 8'h00;
      fill_idx   <= 5'd0;
    end else begin
      rd_char  <= mem[rd_addr];
      wr_pulse <= is_data;
      if (txn_v && !txn_rw && busy) overrun <= 1'b1;
      if (state_q == FILL) begin
        mem[fill_idx] <= 8'h20;
        fill_idx      <= fill_idx + 5'd1;
        if (fill_idx == 5'd31) begin
          ac  <= 7'h00;
          inc <= 1'b1;
        end
      end
      if (is_data) begin
        if (wr_en) mem[wr_idx] <= txn_d;
        ac <= ac_step(ac, inc);
      end
      if (is_instr) begin
        if (op_setac) ac         <= txn_d[6:0];
        if (op_disp)  display_on <= txn_d[2];
        if (op_entry) inc        <= txn_d[1];
        if (op_home)  ac         <= 7'h00;
        if (op_clear) fill_idx   <= 5'd0;
      end
    end
  end

  // Busy holds until both the down-counter expires and any clear fill has finished.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      busy <= 1'b1;
      cnt  <= (is_instr && (op_clear || op_home)) ? CW'(LONG_CYCLES) : CW'(CMD_CYCLES);
    end else if (busy) begin
      if (cnt > CW'(1)) cnt <= cnt - CW'(1);
      else begin
        cnt <= '0;
        if (state_d != FILL) busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder: strobes bus writes and checks the mirror,
// address counter, busy timing, overrun and reset behaviour against hand-computed values.
module tb_lcd_hd44780_responder;

  localparam int CMD  = 20;
  localparam int LONG = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] data_bus = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic       busy, display_on, wr_pulse, overrun;
  logic [6:0] ac;

  int compared = 0, mismatched = 0;
  int busy_run = 0, last_run = 0, wr_cnt = 0;
  int w0;
  logic [7:0] v;

  lcd_hd44780_responder #(.CMD_CYCLES(CMD), .LONG_CYCLES(LONG)) dut (
    .iCLK_50MHZ(clk), .iRST_N(rst_n), .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw),
    .DATA_BUS(data_bus), .rd_addr(rd_addr), .rd_char(rd_char), .busy(busy),
    .display_on(display_on), .ac(ac), .wr_pulse(wr_pulse), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Length of the most recent busy run and number of wr_pulse cycles.
  always @(negedge clk) begin
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
    if (wr_pulse) wr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; data_bus = d; lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0;
    repeat (6) @(negedge clk);
    data_bus = 8'h00; lcd_rs = 1'b0; lcd_rw = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 3000), 32'd1);
    @(negedge clk);
  endtask

  task automatic instr(input logic [7:0] d);
    send(1'b0, 1'b0, d);
    wait_idle();
  endtask

  task automatic wdata(input logic [7:0] d);
    send(1'b1, 1'b0, d);
    wait_idle();
  endtask

  task automatic read_cell(input int idx, output logic [7:0] val);
    @(negedge clk);
    rd_addr = idx[4:0];
    @(negedge clk);
    val = rd_char;
  endtask

  task automatic chk_cell(input string tag, input int idx, input logic [7:0] exp);
    logic [7:0] val;
    read_cell(idx, val);
    chk(tag, {24'd0, val}, {24'd0, exp});
  endtask

  initial begin
    // Reset values apply asynchronously
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ac", {25'd0, ac}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_disp", {31'd0, display_on}, 32'h0);
    chk("rst_wrp", {31'd0, wr_pulse}, 32'h0);
    chk("rst_ovr", {31'd0, overrun}, 32'h0);
    chk("rst_rdc", {24'd0, rd_char}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) chk_cell("rst_cell", i, 8'h20);

    // Display control and ordinary busy length
    instr(8'h0C);
    chk("disp_on", {31'd0, display_on}, 32'h1);
    chk("busy_cmd_len", last_run, CMD);
    instr(8'h08);
    chk("disp_off", {31'd0, display_on}, 32'h0);
    instr(8'h0F);
    chk("disp_on2", {31'd0, display_on}, 32'h1);

    // Writes at end of line 1, third one discarded at 0x10
    w0 = wr_cnt;
    instr(8'h8E);
    wdata(8'h41);
    wdata(8'h42);
    wdata(8'h43);
    chk("busy_data_len", last_run, CMD);
    chk("ac_0x11", {25'd0, ac}, 32'h11);
    chk("wr_pulses3", wr_cnt - w0, 3);
    chk_cell("cell14", 14, 8'h41);
    chk_cell("cell15", 15, 8'h42);
    chk_cell("cell16_untouched", 16, 8'h20);

    // Address counter line wraps in both directions
    instr(8'hA7);
    instr(8'h06);
    wdata(8'h31);
    chk("inc_27_to_40", {25'd0, ac}, 32'h40);
    instr(8'h04);
    wdata(8'h32);
    chk("dec_40_to_27", {25'd0, ac}, 32'h27);
    chk_cell("cell16", 16, 8'h32);
    instr(8'h80);
    wdata(8'h33);
    chk("dec_00_to_67", {25'd0, ac}, 32'h67);
    chk_cell("cell0", 0, 8'h33);
    instr(8'h06);
    wdata(8'h34);
    chk("inc_67_to_00", {25'd0, ac}, 32'h00);
    instr(8'hFF);
    wdata(8'h35);
    chk("inc_7f_to_00", {25'd0, ac}, 32'h00);
    chk_cell("cell0_keep", 0, 8'h33);

    // Return Home uses the long busy time
    instr(8'h85);
    instr(8'h02);
    chk("home_ac", {25'd0, ac}, 32'h0);
    chk("busy_home_len", last_run, LONG);

    // Fill everything, then Clear Display from decrement mode
    instr(8'h80);
    for (int i = 0; i < 16; i++) wdata(8'h55);
    instr(8'hC0);
    for (int i = 0; i < 16; i++) wdata(8'h55);
    chk_cell("fill0", 0, 8'h55);
    chk_cell("fill31", 31, 8'h55);
    instr(8'h04);
    instr(8'h01);
    chk("busy_clear_len", last_run, LONG);
    chk("clear_ac", {25'd0, ac}, 32'h0);
    chk("clear_keeps_disp", {31'd0, display_on}, 32'h1);
    for (int i = 0; i < 32; i++) chk_cell("clear_cell", i, 8'h20);
    wdata(8'h44);
    chk("clear_inc_restored", {25'd0, ac}, 32'h1);
    chk_cell("cell0_after_clear", 0, 8'h44);
    chk("ovr_still_clear", {31'd0, overrun}, 32'h0);

    // Write while busy sets overrun and is dropped
    w0 = wr_cnt;
    send(1'b1, 1'b0, 8'h77);
    send(1'b1, 1'b0, 8'h78);
    wait_idle();
    chk("overrun_set", {31'd0, overrun}, 32'h1);
    chk("overrun_ac", {25'd0, ac}, 32'h2);
    chk("overrun_pulses", wr_cnt - w0, 1);
    chk_cell("overrun_cell1", 1, 8'h77);
    chk_cell("overrun_cell2", 2, 8'h20);

    // RW=1 strobe is ignored
    w0 = wr_cnt;
    send(1'b1, 1'b1, 8'h99);
    repeat (3) @(negedge clk);
    chk("rw_busy", {31'd0, busy}, 32'h0);
    chk("rw_ac", {25'd0, ac}, 32'h2);
    chk("rw_pulses", wr_cnt - w0, 0);
    chk_cell("rw_cell2", 2, 8'h20);

    // Reset in the middle of FILL
    send(1'b0, 1'b0, 8'h01);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midfill_ac", {25'd0, ac}, 32'h0);
    chk("midfill_busy", {31'd0, busy}, 32'h0);
    chk("midfill_disp", {31'd0, display_on}, 32'h0);
    chk("midfill_ovr", {31'd0, overrun}, 32'h0);
    chk("midfill_wrp", {31'd0, wr_pulse}, 32'h0);
    chk("midfill_rdc", {24'd0, rd_char}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_cell("midfill_cell0", 0, 8'h20);
    chk_cell("midfill_cell1", 1, 8'h20);
    repeat (3) @(negedge clk);
    chk("midfill_busy_after", {31'd0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_responder.md
Name: lcd_hd44780_responder

Overview:
- LCD-side model of the HD44780 8-bit write bus: the responder end of the LCD controller interface.
- Samples LCD_E/LCD_RS/LCD_RW/DATA_BUS, decodes instructions and data writes, and keeps a 32-cell (16x2) mirror of display RAM plus address counter, entry mode and busy timing.
- Used on-chip as a display-content monitor and in benches as the checker target for the LCD controller.
- Never drives DATA_BUS.

Parameters:
- CMD_CYCLES, 2000, busy duration in clocks after an ordinary instruction or data write (40 us at 50 MHz).
- LONG_CYCLES, 76500, busy duration in clocks after Clear Display or Return Home (1.53 ms at 50 MHz).

Ports:
- iCLK_50MHZ  input  1  system clock; the only clock.
- iRST_N  input  1  asynchronous, active-low reset.
- LCD_E  input  1  enable strobe from the controller; asynchronous to the clock.
- LCD_RS  input  1  register select: 0 = instruction, 1 = data.
- LCD_RW  input  1  1 = read cycle.
- DATA_BUS  input  8  LCD data lines.
- rd_addr  input  5  mirror cell index: 0-15 are line 1, 16-31 are line 2.
- rd_char  output  8  registered content of cell rd_addr.
- busy  output  1  modelled HD44780 busy flag.
- display_on  output  1  D bit from the last Display Control instruction.
- ac  output  7  current DDRAM address counter.
- wr_pulse  output  1  one-clock pulse per accepted data write.
- overrun  output  1  sticky; set when a transaction arrives while busy.

Behaviour:
- Reset (asynchronous, active-low), values in effect immediately:
  - all 32 cells = 0x20; ac = 0; entry increment = 1.
  - display_on, busy, wr_pulse, overrun, rd_char = 0.
  - synchronizers cleared; clear FSM in IDLE.
- Input capture:
  - LCD_E, LCD_RS, LCD_RW and DATA_BUS pass through two-flop synchronizers.
  - A transaction is a synchronized E high->low transition.
  - RS/RW/DATA are taken from the sync stage holding the last E-high sample.
  - Decode happens in the cycle after the edge is detected.
- Filtering:
  - RW = 1 transactions are ignored entirely; no state change, no overrun.
  - A transaction with busy = 1 sets overrun and is otherwise ignored.
- Instruction decode (RS = 0), highest set bit wins:
  - 1xxxxxxx: ac = D[6:0].
  - 01xxxxxx (CGRAM address), 001xxxxx (Function Set), 0001xxxx (cursor/display shift): accepted for busy timing only.
  - 00001DCB: display_on = D.
  - 000001IS: increment = I; S is ignored.
  - 0000001x (Return Home): ac = 0.
  - 00000001 (Clear Display): clear sequence, then ac = 0 and increment = 1.
  - 0x00: no operation, but busy still asserts.
- Data write (RS = 1):
  - ac 0x00-0x0F writes cell ac[3:0]; ac 0x40-0x4F writes cell 16+ac[3:0].
  - Any other ac value discards the data, but ac still moves and wr_pulse still fires.
  - Write and ac update take effect in the same cycle.
- Address counter movement:
  - Increment: 0x27 -> 0x40; 0x67 -> 0x00; otherwise +1.
  - Decrement: 0x00 -> 0x67; 0x40 -> 0x27; otherwise -1.
  - Values 0x28-0x3F and 0x68-0x7F loaded by Set Address move by plain +/-1 in 7 bits, wrapping 0x7F <-> 0x00.
- Clear FSM, states IDLE -> FILL -> IDLE:
  - FILL writes 0x20 to one cell per clock, index 0 to 31 (32 clocks).
  - ac and increment are updated when FILL ends.
- Busy:
  - busy rises the cycle after decode, for any accepted transaction.
  - Down-counter is loaded with LONG_CYCLES for Clear or Home, CMD_CYCLES otherwise.
  - busy drops when the counter reaches 0.
  - For Clear, busy = 1 covers the whole FILL phase regardless of LONG_CYCLES.
- Read port:
  - rd_char = cell[rd_addr], registered, 1-clock latency.
  - During FILL it returns the partially cleared contents.
  - A data write and a read of the same cell in one cycle return the old value.
- wr_pulse: exactly 1 clock high per accepted data write, even when the data is discarded.
- overrun clears only on reset.
- Reset in the middle of a transaction or FILL: full reset state applies, and any E falling edge in flight is lost.

Test Plan:
- Reset, then read all 32 cells -> every rd_char = 0x20; ac = 0, busy = 0, display_on = 0.
- Send 0x0C, wait until not busy -> display_on = 1; busy high for exactly CMD_CYCLES clocks.
- Set ac 0x0E, then data 'A','B','C' with increment -> cells 14 and 15 = 0x41/0x42; 0x43 discarded at 0x10; ac = 0x11; three wr_pulse.
- Set ac 0x27, entry 0x06, one data byte -> ac = 0x40. Entry 0x04 at ac 0x40, one data byte -> cell 16 written, ac = 0x27.
- Fill cells with 0x55, send 0x01 -> busy for LONG_CYCLES; all cells 0x20 after 32 clocks; ac = 0, increment = 1.
- Send data while busy -> overrun = 1, no cell or ac change. RW = 1 strobe -> no effect. Assert iRST_N low mid-FILL -> all outputs at reset values immediately.
